data_mem_responder: RTL and testbench

Data-memory responder for the RV32I core: the slave end of the core's load/store path. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte/half/word access with RISC-V funct3 semantics: sign/zero extension and lane placement. It returns a response with read data or an error flag. It replaces the core's internal RAM array once the core moves to a multi-cycle memory interface.

---
 rtl/data_mem_responder.sv | 91 +++++++++
 tb/tb_data_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32I data-memory slave with valid/ready request/response, programmable wait states
// and funct3 byte/half/word access with sign/zero extension.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] W_LOAD = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic        idle, a_we, do_acc, bad_f3, misal, oor, err;
   logic [2:0]  a_f3;
   logic [31:0] a_addr, a_wdata, word, ld, wd;
   logic [IW-1:0] widx;
   logic [7:0]  bt;
   logic [15:0] hw;
   logic [3:0]  be;
   assign idle      = state == S_IDLE;
   assign req_ready = idle;
   assign rsp_valid = state == S_RESP;
   // With zero wait states the access happens on the accept edge, straight from the request inputs
   assign a_we    = idle ? req_we : we_q;
   assign a_f3    = idle ? req_funct3 : f3_q;
   assign a_addr  = idle ? req_addr : addr_q;
   assign a_wdata = idle ? req_wdata : wdata_q;
   assign do_acc  = idle ? (WAIT_CYCLES == 0 && req_valid) : (state == S_WAIT && cnt == 4'd0);
   assign bad_f3  = a_we ? a_f3 > 3'd2 : (a_f3 == 3'd3 || a_f3[2:1] == 2'b11);
   assign misal   = (a_f3[1:0] == 2'd1 && a_addr[0]) || (a_f3[1:0] == 2'd2 && a_addr[1:0] != 2'd0);
   assign oor     = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign err     = bad_f3 || misal || oor;
   assign widx    = a_addr[IW+1:2];
   assign word    = mem[widx];
   assign bt      = word[{a_addr[1:0], 3'b000} +: 8];
   assign hw      = a_addr[1] ? word[31:16] : word[15:0];
   assign ld      = a_f3[1:0] == 2'd0 ? {{24{~a_f3[2] & bt[7]}}, bt} :
                    a_f3[1:0] == 2'd1 ? {{16{~a_f3[2] & hw[15]}}, hw} : word;
   assign be      = a_f3[1:0] == 2'd0 ? 4'b0001 << a_addr[1:0] :
                    a_f3[1:0] == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wd      = a_f3[1:0] == 2'd0 ? {4{a_wdata[7:0]}} :
                    a_f3[1:0] == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
   always_ff @(posedge clk)
      for (int b = 0; b < 4; b++)
         if (do_acc && a_we && !err && be[b]) mem[widx][b*8 +: 8] <= wd[b*8 +: 8];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         we_q      <= 1'b0;
         f3_q      <= 3'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         if (idle && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= W_LOAD;
            state   <= WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
         end else if (state == S_WAIT) begin
            if (cnt == 4'd0) state <= S_RESP;
            else cnt <= cnt - 4'd1;
         end else if (state == S_RESP && rsp_ready) state <= S_IDLE;
         if (do_acc) begin
            rsp_rdata <= (err || a_we) ? 32'd0 : ld;
            rsp_err   <= err;
         end
      end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a byte-addressed
// reference memory model; a second zero-wait instance covers back-to-back throughput.
module tb_data_mem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;
   logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [2:0] req_funct3;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [2:0] req_funct30;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
   int checks = 0;
   int failures = 0;
   logic [31:0] mw [256];

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
      .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

   // Byte-level reference: walk the accessed bytes by address, then extend arithmetically
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n, idx, s;
      logic legal;
      n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : !(f3 inside {3'd3, 3'd6, 3'd7});
      er = !legal || (a % n) != 0 || (a / 4) >= 256;
      rd = 32'd0;
      if (er) return;
      for (int k = 0; k < n; k++) begin
         idx = int'((a + k) / 4);
         s = int'((a + k) % 4) * 8;
         if (we) mw[idx] = (mw[idx] & ~(32'hFF << s)) | (((wd >> (8 * k)) & 32'hFF) << s);
         else rd = rd | (((mw[idx] >> s) & 32'hFF) << (8 * k));
      end
      if (!we && f3 < 3'd4 && n < 4 && rd[8*n-1]) rd = rd - (32'd1 << (8 * n));
   endfunction

   // Issue one request at a negedge in IDLE; returns response and edges from accept to rsp_valid
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) lat = -1;
      rd = rsp_rdata; er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] rd, mrd;
      logic er, mer;
      int lat;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1 checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL reset_init: got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0", req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int w = 0; w < 64; w++) begin
         model(1'b1, 3'd2, 32'(w * 4), 32'd0, mrd, mer);
         do_txn(1'b1, 3'd2, 32'(w * 4), 32'd0, rd, er, lat);
      end
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1 checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL reset_mid_wait: got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0", req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      do_txn(1'b0, 3'd2, 32'h10, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'd0 || er !== 1'b0) begin
         failures++;
         $display("FAIL aborted_store: got rdata=%h err=%b want 00000000 0", rd, er);
      end
      model(1'b1, 3'd2, 32'h14, 32'h5A5A1234, mrd, mer);
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h14; req_wdata = 32'h5A5A1234; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      do_txn(1'b0, 3'd2, 32'h14, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'h5A5A1234 || er !== 1'b0) begin
         failures++;
         $display("FAIL committed_store: got rdata=%h err=%b want 5a5a1234 0", rd, er);
      end
   endtask

   task automatic test_word();
      logic [31:0] rd, mrd;
      logic er, mer;
      int lat;
      model(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, mrd, mer);
      do_txn(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, rd, er, lat);
      checks++;
      if (rd !== 32'd0 || er !== 1'b0 || lat != 1) begin
         failures++;
         $display("FAIL sw_word: got rdata=%h err=%b lat=%0d want 00000000 0 1", rd, er, lat);
      end
      do_txn(1'b0, 3'd2, 32'h20, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 1) begin
         failures++;
         $display("FAIL lw_word: got rdata=%h err=%b lat=%0d want deadbeef 0 1", rd, er, lat);
      end
   endtask

   task automatic test_lanes();
      logic [31:0] rd, mrd;
      logic er, mer;
      int lat;
      logic [2:0]  f3s [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
      logic [31:0] ads [5] = '{32'h40, 32'h41, 32'h41, 32'h42, 32'h42};
      logic [31:0] exp [5] = '{32'hBBCCAA44, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFBBCC, 32'h0000BBCC};
      model(1'b1, 3'd2, 32'h40, 32'h11223344, mrd, mer);
      do_txn(1'b1, 3'd2, 32'h40, 32'h11223344, rd, er, lat);
      model(1'b1, 3'd0, 32'h41, 32'h123456AA, mrd, mer);
      do_txn(1'b1, 3'd0, 32'h41, 32'h123456AA, rd, er, lat);
      model(1'b1, 3'd1, 32'h42, 32'h9999BBCC, mrd, mer);
      do_txn(1'b1, 3'd1, 32'h42, 32'h9999BBCC, rd, er, lat);
      for (int i = 0; i < 5; i++) begin
         do_txn(1'b0, f3s[i], ads[i], 32'd0, rd, er, lat);
         checks++;
         if (rd !== exp[i] || er !== 1'b0) begin
            failures++;
            $display("FAIL lane_load%0d: f3=%0d addr=%h got rdata=%h err=%b want %h 0", i, f3s[i], ads[i], rd, er, exp[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic er;
      int lat;
      logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd2, 3'd2, 3'd3};
      logic [31:0] ads [5] = '{32'h22, 32'h23, 32'h20, 32'h400, 32'h20};
      logic        ers [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] exp [5] = '{32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
      for (int i = 0; i < 5; i++) begin
         do_txn(wes[i], f3s[i], ads[i], 32'h77665544, rd, er, lat);
         checks++;
         if (rd !== exp[i] || er !== ers[i]) begin
            failures++;
            $display("FAIL err_case%0d: we=%b f3=%0d addr=%h got rdata=%h err=%b want %h %b", i, wes[i], f3s[i], ads[i], rd, er, exp[i], ers[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic er;
      int lat, n;
      req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      for (int c = 0; c < 5; c++) begin
         req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h0; req_valid = 1'b1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBBCCAA44 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_c%0d: got vld=%b rdata=%h err=%b rdy=%b want 1 bbccaa44 0 0", c, rsp_valid, rsp_rdata, rsp_err, req_ready);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
      end
      do_txn(1'b0, 3'd2, 32'h40, 32'd0, rd, er, lat);
      checks++;
      if (rd !== 32'hBBCCAA44 || er !== 1'b0) begin
         failures++;
         $display("FAIL bp_ignored_req: got rdata=%h err=%b want bbccaa44 0", rd, er);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, mrd, a, wd;
      logic er, mer, we;
      logic [2:0] f3;
      int lat;
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a = $urandom_range(0, 9) == 0 ? ($urandom | 32'h400) : 32'($urandom_range(0, 255));
         wd = $urandom;
         model(we, f3, a, wd, mrd, mer);
         do_txn(we, f3, a, wd, rd, er, lat);
         checks++;
         if (rd !== mrd || er !== mer || lat != 1) begin
            failures++;
            $display("FAIL random%0d: we=%b f3=%0d addr=%h got rdata=%h err=%b lat=%0d want %h %b 1", i, we, f3, a, rd, er, lat, mrd, mer);
         end
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] vals [8];
      time t_prev;
      rsp_ready0 = 1'b1;
      req_valid0 = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 8) vals[i] = $urandom;
         req_we0 = i < 8; req_funct30 = 3'd2; req_addr0 = 32'((i % 8) * 4); req_wdata0 = vals[i % 8];
         checks++;
         if (req_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL zw_ready%0d: got rdy=%b want 1", i, req_ready0);
         end
         @(posedge clk);
         if (i > 0) begin
            checks++;
            if ($time - t_prev != 20) begin
               failures++;
               $display("FAIL zw_interval%0d: got %0t want 20", i, $time - t_prev);
            end
         end
         t_prev = $time;
         @(negedge clk);
         checks++;
         if (rsp_valid0 !== 1'b1 || req_ready0 !== 1'b0 || rsp_err0 !== 1'b0 ||
             rsp_rdata0 !== (i < 8 ? 32'd0 : vals[i % 8])) begin
            failures++;
            $display("FAIL zw_rsp%0d: got vld=%b rdy=%b err=%b rdata=%h want 1 0 0 %h", i, rsp_valid0, req_ready0, rsp_err0, rsp_rdata0, i < 8 ? 32'd0 : vals[i % 8]);
         end
         @(posedge clk);
         @(negedge clk);
      end
      req_valid0 = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mw[i] = 32'd0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
      req_valid0 = 1'b0; req_we0 = 1'b0; req_funct30 = 3'd0; req_addr0 = 32'd0; req_wdata0 = 32'd0; rsp_ready0 = 1'b0;
      test_reset();
      test_word();
      test_lanes();
      test_errors();
      test_backpressure();
      test_random();
      test_zero_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
